// File: rtl/my_uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : my_uart_tx_if
// Brief    : Byte valid/ready handshake between a requester and my_uart_tx.
// Revision : 1.0 - initial release
// ============================================================================
interface my_uart_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (output tx_data, output tx_valid, input  tx_ready);
   modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface
`default_nettype wire

// File: rtl/my_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : my_uart_tx
// Brief    : RS-232 serialiser: start, 8 data bits LSB first, optional parity,
//            STOP_BITS stop bits, BAUD_DIV clocks per bit.
// Revision : 1.0 - initial release
// ============================================================================
module my_uart_tx #(
   parameter int BAUD_DIV  = 5200,
   parameter int STOP_BITS = 1
) (
   input  wire logic       clk,
   input  wire logic       rst_n,
   my_uart_tx_if.slave     tx_if,
   input  wire logic       r_tx_en,
   input  wire logic [1:0] r_pari_mode,
   output logic            rs232_tx,
   output logic            tx_busy,
   output logic            int_tx_finish
);

   localparam logic [2:0]  S_IDLE   = 3'd0;
   localparam logic [2:0]  S_START  = 3'd1;
   localparam logic [2:0]  S_DATA   = 3'd2;
   localparam logic [2:0]  S_PARITY = 3'd3;
   localparam logic [2:0]  S_STOP   = 3'd4;

   localparam logic [15:0] c_BAUD_LAST = 16'(BAUD_DIV - 1);
   localparam logic        c_STOP_LAST = 1'(STOP_BITS - 1);

   logic [2:0]  r_state;
   logic [15:0] r_baud_cnt;
   logic [2:0]  r_bit_idx;
   logic        r_stop_idx;
   logic [7:0]  r_shift;
   logic        r_parity;
   logic        r_par_en;
   logic        r_line;
   logic        r_finish;

   logic        w_bit_end;
   logic        w_accept;

   assign w_bit_end      = (r_baud_cnt == c_BAUD_LAST);
   assign tx_if.tx_ready = (r_state == S_IDLE) & r_tx_en;
   assign w_accept       = tx_if.tx_valid & tx_if.tx_ready;

   assign rs232_tx       = r_line;
   assign tx_busy        = (r_state != S_IDLE);
   assign int_tx_finish  = r_finish;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_baud_cnt <= 16'd0;
         r_bit_idx  <= 3'd0;
         r_stop_idx <= 1'b0;
         r_shift    <= 8'd0;
         r_parity   <= 1'b0;
         r_par_en   <= 1'b0;
         r_line     <= 1'b1;
         r_finish   <= 1'b0;
      end else begin
         r_finish <= 1'b0;
         if (r_state != S_IDLE) begin
            r_baud_cnt <= w_bit_end ? 16'd0 : r_baud_cnt + 16'd1;
         end
         case (r_state)
            S_IDLE: begin
               r_line     <= 1'b1;
               r_baud_cnt <= 16'd0;
               if (w_accept) begin
                  r_shift  <= tx_if.tx_data;
                  r_par_en <= (r_pari_mode == 2'b01) || (r_pari_mode == 2'b10);
                  r_parity <= (r_pari_mode == 2'b01) ? ~^tx_if.tx_data : ^tx_if.tx_data;
                  r_line   <= 1'b0;
                  r_state  <= S_START;
               end
            end
            S_START: begin
               if (w_bit_end) begin
                  // The shift register always presents the next data bit at [0].
                  r_line    <= r_shift[0];
                  r_shift   <= {1'b0, r_shift[7:1]};
                  r_bit_idx <= 3'd0;
                  r_state   <= S_DATA;
               end
            end
            S_DATA: begin
               if (w_bit_end) begin
                  if (r_bit_idx == 3'd7) begin
                     r_stop_idx <= 1'b0;
                     r_line     <= r_par_en ? r_parity : 1'b1;
                     r_state    <= r_par_en ? S_PARITY : S_STOP;
                  end else begin
                     r_line    <= r_shift[0];
                     r_shift   <= {1'b0, r_shift[7:1]};
                     r_bit_idx <= r_bit_idx + 3'd1;
                  end
               end
            end
            S_PARITY: begin
               if (w_bit_end) begin
                  r_stop_idx <= 1'b0;
                  r_line     <= 1'b1;
                  r_state    <= S_STOP;
               end
            end
            S_STOP: begin
               if (w_bit_end) begin
                  if (r_stop_idx == c_STOP_LAST) begin
                     r_finish <= 1'b1;
                     r_state  <= S_IDLE;
                  end else begin
                     r_stop_idx <= 1'b1;
                  end
               end
            end
            default: begin
               r_line  <= 1'b1;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_my_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_my_uart_tx
// Brief    : Self-checking bench for my_uart_tx with a mid-bit line sampler.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_my_uart_tx;

   localparam int B  = 16;
   localparam int SB = 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       r_tx_en = 1'b0;
   logic [1:0] r_pari_mode = 2'b00;
   logic       rs232_tx;
   logic       tx_busy;
   logic       int_tx_finish;

   int total = 0;
   int bad   = 0;

   my_uart_tx_if tx_if ();

   my_uart_tx #(.BAUD_DIV(B), .STOP_BITS(SB)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .tx_if         (tx_if.slave),
      .r_tx_en       (r_tx_en),
      .r_pari_mode   (r_pari_mode),
      .rs232_tx      (rs232_tx),
      .tx_busy       (tx_busy),
      .int_tx_finish (int_tx_finish)
   );

   always #10 clk = ~clk;

   function automatic bit has_parity(input logic [1:0] m);
      return (m == 2'b01) || (m == 2'b10);
   endfunction

   function automatic int frame_bits(input logic [1:0] m);
      return 1 + 8 + (has_parity(m) ? 1 : 0) + SB;
   endfunction

   // Expected line level during bit slot k of a frame.
   function automatic logic exp_bit(input logic [7:0] d, input logic [1:0] m, input int k);
      int ones;
      ones = $countones(d);
      if (k == 0) return 1'b0;
      if (k <= 8) return d[k-1];
      if (k == 9 && has_parity(m)) return (m == 2'b01) ? ((ones % 2) == 0) : ((ones % 2) == 1);
      return 1'b1;
   endfunction

   task automatic wait_accept(output bit ok, output int waited);
      ok = 1'b0;
      waited = 0;
      #1;
      for (int i = 0; i < 200; i++) begin
         if (tx_if.tx_ready && tx_if.tx_valid) begin
            @(posedge clk);
            ok = 1'b1;
            waited = i;
            return;
         end
         @(negedge clk);
      end
   endtask

   task automatic check_frame(input logic [7:0] d, input logic [1:0] m, input bit keep,
                              input logic [7:0] nd, input logic [1:0] nm, input int drop_en,
                              input string name);
      int n;
      int pulses;
      int pcyc;
      int k;
      logic [7:0] got;
      n = frame_bits(m);
      pulses = 0;
      pcyc = -1;
      got = 8'h00;
      for (int c = 0; c <= n * B; c++) begin
         @(negedge clk);
         if (c == 0) begin
            total++;
            if (rs232_tx !== 1'b0) begin bad++; $display("FAIL %s start_latency got=%b want=0", name, rs232_tx); end
            total++;
            if (tx_busy !== 1'b1) begin bad++; $display("FAIL %s busy_at_start got=%b want=1", name, tx_busy); end
            if (keep) begin
               tx_if.tx_data = nd;
               r_pari_mode = nm;
            end else begin
               tx_if.tx_valid = 1'b0;
               tx_if.tx_data = 8'($urandom);
               r_pari_mode = 2'($urandom);
            end
         end
         if (c == drop_en) r_tx_en = 1'b0;
         if (int_tx_finish === 1'b1) begin
            pulses++;
            if (pcyc < 0) pcyc = c;
         end
         if (c < n * B && (c % B) == B / 2) begin
            k = c / B;
            total++;
            if (rs232_tx !== exp_bit(d, m, k))
               begin bad++; $display("FAIL %s bit%0d got=%b want=%b", name, k, rs232_tx, exp_bit(d, m, k)); end
            if (k >= 1 && k <= 8) got[k-1] = rs232_tx;
         end
      end
      total++;
      if (got !== d) begin bad++; $display("FAIL %s decoded got=%h want=%h", name, got, d); end
      total++;
      if (pulses != 1) begin bad++; $display("FAIL %s finish_pulses got=%0d want=1", name, pulses); end
      total++;
      if (pcyc != n * B) begin bad++; $display("FAIL %s finish_cycle got=%0d want=%0d", name, pcyc, n * B); end
      total++;
      if (tx_busy !== 1'b0) begin bad++; $display("FAIL %s busy_at_end got=%b want=0", name, tx_busy); end
   endtask

   task automatic send(input logic [7:0] d, input logic [1:0] m, input bit keep,
                       input logic [7:0] nd, input logic [1:0] nm, input int drop_en,
                       input string name, output int waited);
      bit ok;
      tx_if.tx_data = d;
      r_pari_mode = m;
      tx_if.tx_valid = 1'b1;
      wait_accept(ok, waited);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s accept got=timeout want=accepted", name);
         tx_if.tx_valid = 1'b0;
         return;
      end
      check_frame(d, m, keep, nd, nm, drop_en, name);
   endtask

   task automatic test_reset();
      int errs;
      rst_n = 1'b0;
      r_tx_en = 1'b1;
      tx_if.tx_valid = 1'b0;
      tx_if.tx_data = 8'h00;
      @(negedge clk);
      total++;
      if ({rs232_tx, tx_busy, int_tx_finish, tx_if.tx_ready} !== 4'b1001)
         begin bad++; $display("FAIL reset_outputs got=%b want=1001", {rs232_tx, tx_busy, int_tx_finish, tx_if.tx_ready}); end
      rst_n = 1'b1;
      errs = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if ({rs232_tx, tx_busy, int_tx_finish, tx_if.tx_ready} !== 4'b1001) errs++;
      end
      total++;
      if (errs != 0) begin bad++; $display("FAIL idle_hold got=%0d_bad_cycles want=0", errs); end
   endtask

   task automatic test_basic();
      int w;
      send(8'h55, 2'b00, 1'b0, 8'h00, 2'b00, -1, "basic_55", w);
      send(8'hA3, 2'b11, 1'b0, 8'h00, 2'b00, -1, "mode11_A3", w);
   endtask

   task automatic test_parity();
      int w;
      send(8'h12, 2'b01, 1'b0, 8'h00, 2'b00, -1, "par_12_odd", w);
      send(8'h12, 2'b10, 1'b0, 8'h00, 2'b00, -1, "par_12_even", w);
      send(8'hFF, 2'b10, 1'b0, 8'h00, 2'b00, -1, "par_FF_even", w);
      send(8'h00, 2'b01, 1'b0, 8'h00, 2'b00, -1, "par_00_odd", w);
   endtask

   task automatic test_handshake();
      int errs;
      int w;
      r_tx_en = 1'b0;
      tx_if.tx_data = 8'hAA;
      r_pari_mode = 2'b00;
      tx_if.tx_valid = 1'b1;
      errs = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (rs232_tx !== 1'b1 || tx_busy !== 1'b0 || tx_if.tx_ready !== 1'b0) errs++;
      end
      total++;
      if (errs != 0) begin bad++; $display("FAIL gated_by_en got=%0d_bad_cycles want=0", errs); end
      r_tx_en = 1'b1;
      send(8'hAA, 2'b00, 1'b0, 8'h00, 2'b00, 3 * B + 2, "en_drop_AA", w);
      total++;
      if (w != 0) begin bad++; $display("FAIL en_raise_latency got=%0d want=0", w); end
      total++;
      if (tx_if.tx_ready !== 1'b0) begin bad++; $display("FAIL ready_with_en_low got=%b want=0", tx_if.tx_ready); end
      r_tx_en = 1'b1;
   endtask

   task automatic test_back_to_back();
      int w;
      send(8'h00, 2'b00, 1'b1, 8'hFF, 2'b00, -1, "b2b_first", w);
      send(8'hFF, 2'b00, 1'b0, 8'h00, 2'b00, -1, "b2b_second", w);
      total++;
      if (w > 1) begin bad++; $display("FAIL b2b_gap got=%0d want<=1", w); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int w;
      int errs;
      tx_if.tx_data = 8'h34;
      r_pari_mode = 2'b00;
      tx_if.tx_valid = 1'b1;
      wait_accept(ok, w);
      total++;
      if (!ok) begin bad++; $display("FAIL rst_mid_accept got=timeout want=accepted"); end
      for (int c = 0; c <= 4 * B + B / 2; c++) begin
         @(negedge clk);
         if (c == 0) tx_if.tx_valid = 1'b0;
      end
      total++;
      if (rs232_tx !== 1'b0) begin bad++; $display("FAIL rst_mid_bit3 got=%b want=0", rs232_tx); end
      rst_n = 1'b0;
      #1;
      total++;
      if ({rs232_tx, tx_busy, int_tx_finish} !== 3'b100)
         begin bad++; $display("FAIL rst_mid_async got=%b want=100", {rs232_tx, tx_busy, int_tx_finish}); end
      @(negedge clk);
      rst_n = 1'b1;
      errs = 0;
      for (int i = 0; i < 12 * B; i++) begin
         @(negedge clk);
         if (int_tx_finish !== 1'b0 || rs232_tx !== 1'b1) errs++;
      end
      total++;
      if (errs != 0) begin bad++; $display("FAIL rst_mid_abandon got=%0d_bad_cycles want=0", errs); end
      send(8'h34, 2'b00, 1'b0, 8'h00, 2'b00, -1, "after_rst_34", w);
   endtask

   task automatic test_random();
      int w;
      logic [7:0] d;
      logic [1:0] m;
      for (int i = 0; i < 49; i++) begin
         d = 8'($urandom);
         m = 2'($urandom);
         send(d, m, 1'b0, 8'h00, 2'b00, -1, "random", w);
      end
   endtask

   initial begin
      tx_if.tx_data = 8'h00;
      tx_if.tx_valid = 1'b0;
      test_reset();
      test_basic();
      test_parity();
      test_handshake();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout want=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
